// File: rtl/mem_access_ctrl.sv
// Load/store unit bus master: turns EX-stage memory requests into a registered
// request/ack bus transaction. Define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable_in,
  input  logic        mem_rw_in,
  input  logic        mem_size_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        rdata_valid_out,
  output logic        align_err_out,
  output logic        timeout_err_out,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        aligned;
  logic        accept;
  logic        ack_hit;
  logic        timeout_hit;
  logic        size_q;
  logic [1:0]  lane_q;

  // Bytes can sit on any lane; words must start on a 4-byte boundary.
  assign aligned = mem_size_in | (addr_in[1:0] == 2'b00);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is given a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    stall_out  = 1'b0;
    accept     = 1'b0;
    ack_hit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_enable_in && aligned) begin
          accept     = 1'b1;
          stall_out  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        stall_out = 1'b1;
        if (bus_ack) begin
          ack_hit    = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_be          <= '0;
      bus_wdata       <= '0;
      size_q          <= 1'b0;
      lane_q          <= '0;
      rdata_out       <= '0;
      rdata_valid_out <= 1'b0;
      align_err_out   <= 1'b0;
    end else begin
      rdata_valid_out <= 1'b0;
      align_err_out   <= 1'b0;

      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= mem_rw_in;
        bus_addr  <= {addr_in[31:2], 2'b00};
        bus_be    <= mem_size_in ? (4'b0001 << addr_in[1:0]) : 4'hF;
        bus_wdata <= mem_size_in ? {4{wdata_in[7:0]}} : wdata_in;
        size_q    <= mem_size_in;
        lane_q    <= addr_in[1:0];
      end else if (state == IDLE && mem_enable_in) begin
        align_err_out <= 1'b1;
      end

      if (ack_hit) begin
        bus_req <= 1'b0;
        if (!bus_we) begin
          rdata_out       <= size_q ? {24'b0, bus_rdata[{lane_q, 3'b000} +: 8]} : bus_rdata;
          rdata_valid_out <= 1'b1;
        end
      end else if (timeout_hit) begin
        bus_req <= 1'b0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] wait_cnt;

  // Fires on the last permitted ack-less BUSY cycle; the abort lands next edge.
  assign timeout_hit = (state == BUSY) && !bus_ack &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt        <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      timeout_err_out <= timeout_hit;
      if (state != BUSY)  wait_cnt <= '0;
      else if (!bus_ack)  wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
  assign timeout_err_out    = 1'b0;
`endif

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max cycles in BUSY awaiting bus_ack (used only with MEM_TIMEOUT_EN).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 mem_enable_in  input  1  EX-stage memory operation request.
REQ-005 mem_rw_in  input  1  1=write, 0=read.
REQ-006 mem_size_in  input  1  0=word (32b), 1=byte.
REQ-007 addr_in  input  32  byte address from ALU.
REQ-008 wdata_in  input  32  store data; byte stores use bits [7:0].
REQ-009 stall_out  output  1  holds upstream pipeline registers while high.
REQ-010 rdata_out  output  32  load result, zero-extended for byte loads.
REQ-011 rdata_valid_out  output  1  one-cycle pulse, rdata_out valid.
REQ-012 align_err_out  output  1  one-cycle pulse, misaligned word access rejected.
REQ-013 timeout_err_out  output  1  one-cycle pulse, bus timeout abort.
REQ-014 bus_req  output  1  bus request, registered.
REQ-015 bus_we  output  1  bus write enable, registered.
REQ-016 bus_addr  output  32  word-aligned bus address (addr[1:0] forced 0), registered.
REQ-017 bus_be  output  4  byte enables, registered.
REQ-018 bus_wdata  output  32  bus write data, registered.
REQ-019 bus_ack  input  1  responder completion, single-cycle.
REQ-020 bus_rdata  input  32  read data, valid with bus_ack.

Function
REQ-021 FSM states IDLE, BUSY, DONE; IDLE after reset.
REQ-022 IDLE: mem_enable_in=1 and aligned -> latch request into bus_* registers, bus_req=1 next cycle, go BUSY.
REQ-023 Aligned: byte always; word only when addr_in[1:0]=0.
REQ-024 IDLE, mem_enable_in=1, misaligned word -> no bus access, align_err_out=1 next cycle, stay IDLE, stall_out not asserted.
REQ-025 Word: bus_be=4'hF, bus_wdata=wdata_in; byte: bus_be=4'b0001<<addr_in[1:0], bus_wdata={4{wdata_in[7:0]}}.
REQ-026 BUSY: bus_req, bus_we, bus_addr, bus_be, bus_wdata held stable until bus_ack sampled high.
REQ-027 BUSY with bus_ack=1 -> DONE; bus_req=0 from next cycle; on read, rdata_out captures bus_rdata (word) or {24'b0, selected lane by latched addr[1:0]} (byte).
REQ-028 DONE: rdata_valid_out=1 for reads only, exactly one cycle; unconditional return to IDLE; mem_enable_in ignored in DONE.
REQ-029 stall_out combinational = (IDLE & mem_enable_in & aligned) | BUSY; low in DONE.
REQ-030 Request-to-DONE latency with immediate ack: 2 cycles; each extra ack-wait cycle adds one.
REQ-031 bus_ack in IDLE or DONE ignored.
REQ-032 rdata_out holds last value until next read completion.

Reset
REQ-033 reset=1 at clk edge: state IDLE; bus_req, bus_we, rdata_valid_out, align_err_out, timeout_err_out=0; bus_addr, bus_be, bus_wdata, rdata_out=0; timeout counter=0.
REQ-034 Reset mid-BUSY aborts transaction: bus_req low next cycle, no rdata_valid_out or error pulse.
REQ-035 Reset has priority over all other inputs.

Configuration
REQ-036 Macro MEM_TIMEOUT_EN defined: counter increments each BUSY cycle without ack; reaching TIMEOUT_CYCLES -> return IDLE, bus_req=0, timeout_err_out=1 one cycle, no rdata_valid_out, counter cleared on BUSY entry.
REQ-037 MEM_TIMEOUT_EN undefined: BUSY waits indefinitely; timeout_err_out tied 0; port list unchanged.

Verification
REQ-038 Word read 0x100, ack on 1st BUSY cycle, bus_rdata=0xDEADBEEF -> bus_be=F, rdata_out=0xDEADBEEF, rdata_valid_out 1 cycle, stall_out high 2 cycles.
REQ-039 Byte write 0x103, wdata=0x5A, ack after 3 cycles -> bus_addr=0x100, bus_be=4'b1000, bus_wdata=0x5A5A5A5A held stable, no rdata_valid_out.
REQ-040 Byte read 0x202, bus_rdata=0x11223344 -> rdata_out=0x00000022.
REQ-041 Word access 0x101 -> align_err_out 1 cycle, bus_req never asserted, stall_out low.
REQ-042 Reset asserted during BUSY -> bus_req 0 next cycle, state IDLE, no pulses; later request serviced normally.
REQ-043 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack withheld -> timeout_err_out after 16 BUSY cycles, stall_out released; without macro, stall_out stays high.
